// File: rtl/mem_pkg.sv
// Shared constants, state and error encodings for the MEM-stage load/store unit.
package mem_pkg;

  localparam int TIMEOUT_CYC_DEF = 255;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } err_e;

  // Illegal encodings take priority over alignment faults.
  function automatic err_e classify(input logic we, input logic re,
                                    input logic [2:0] f3, input logic [1:0] a);
    err_e e;
    e = ERR_OK;
    if (we && re) begin
      e = ERR_ILLEGAL;
    end else if (re) begin
      case (f3)
        LB, LBU: e = ERR_OK;
        LH, LHU: e = a[0] ? ERR_MISALIGN : ERR_OK;
        LW:      e = (a != 2'b00) ? ERR_MISALIGN : ERR_OK;
        default: e = ERR_ILLEGAL;
      endcase
    end else begin
      case (f3)
        SB:      e = ERR_OK;
        SH:      e = a[0] ? ERR_MISALIGN : ERR_OK;
        SW:      e = (a != 2'b00) ? ERR_MISALIGN : ERR_OK;
        default: e = ERR_ILLEGAL;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_fmt.sv
// Load lane select and sign/zero extension of a returned bus word.
module load_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign byte_s = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_s = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      LB:      data_o = {{24{byte_s[7]}}, byte_s};
      LBU:     data_o = {24'b0, byte_s};
      LH:      data_o = {{16{half_s[15]}}, half_s};
      LHU:     data_o = {16'b0, half_s};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one data-bus transaction per memory op, stalls upstream while busy.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] aluc_i,
  input  logic [31:0] rD2_i,
  input  logic        ram_we_i,
  input  logic        ram_re_i,
  input  logic [2:0]  mem_op_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  err_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_wstrb_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [31:2]       addr_q, addr_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        op_q, op_d;
  logic              we_q, we_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  err_e              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              start;
  logic              cnt_last;
  err_e              start_err;
  logic [3:0]        fmt_wstrb;
  logic [31:0]       fmt_wdata;
  logic [31:0]       ld_data;

  assign start     = (state_q == ST_IDLE) && valid_i && (ram_we_i || ram_re_i);
  assign start_err = classify(ram_we_i, ram_re_i, mem_op_i, aluc_i[1:0]);
  assign cnt_last  = (cnt_q == CNT_LAST);

  always_comb begin
    fmt_wstrb = 4'b0000;
    fmt_wdata = rD2_i;
    case (mem_op_i)
      SB: begin
        fmt_wstrb = 4'b0001 << aluc_i[1:0];
        fmt_wdata = {4{rD2_i[7:0]}};
      end
      SH: begin
        fmt_wstrb = 4'b0011 << aluc_i[1:0];
        fmt_wdata = {2{rD2_i[15:0]}};
      end
      SW: begin
        fmt_wstrb = 4'b1111;
        fmt_wdata = rD2_i;
      end
      default: begin
        fmt_wstrb = 4'b0000;
        fmt_wdata = rD2_i;
      end
    endcase
  end

  load_fmt u_load_fmt (
    .addr_i   (lane_q),
    .funct3_i (op_q),
    .rdata_i  (dbus_rdata_i),
    .data_o   (ld_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    op_d    = op_q;
    we_d    = we_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = aluc_i[31:2];
          lane_d  = aluc_i[1:0];
          op_d    = mem_op_i;
          we_d    = ram_we_i;
          wstrb_d = fmt_wstrb;
          wdata_d = fmt_wdata;
          cnt_d   = '0;
          if (start_err != ERR_OK) begin
            state_d = ST_DONE;
            err_d   = start_err;
            rdata_d = '0;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // A completing handshake wins over a timeout landing in the same cycle.
        if (dbus_gnt_i && (we_q || dbus_rvalid_i)) begin
          state_d = ST_DONE;
          err_d   = ERR_OK;
          rdata_d = we_q ? 32'h0 : ld_data;
        end else if (cnt_last) begin
          state_d = ST_DONE;
          err_d   = ERR_TIMEOUT;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (dbus_gnt_i) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (dbus_rvalid_i) begin
          state_d = ST_DONE;
          err_d   = ERR_OK;
          rdata_d = ld_data;
        end else if (cnt_last) begin
          state_d = ST_DONE;
          err_d   = ERR_TIMEOUT;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      lane_q  <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      op_q    <= op_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_o      = start || (state_q == ST_REQ) || (state_q == ST_RESP);
  assign done_o       = (state_q == ST_DONE);
  assign rdata_o      = rdata_q;
  assign err_o        = err_q;
  assign dbus_req_o   = (state_q == ST_REQ);
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = {addr_q, 2'b00};
  assign dbus_wstrb_o = wstrb_q;
  assign dbus_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized scoreboard bench for mem_stage_lsu against a rule-level reference model.
module tb_mem_stage_lsu;

  localparam int TO    = 8;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] aluc_i = '0;
  logic [31:0] rD2_i = '0;
  logic        ram_we_i = 1'b0;
  logic        ram_re_i = 1'b0;
  logic [2:0]  mem_op_i = '0;
  logic        stall_o, done_o;
  logic [31:0] rdata_o;
  logic [1:0]  err_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_wstrb_o;
  logic        dbus_gnt_i = 1'b0;
  logic        dbus_rvalid_i = 1'b0;
  logic [31:0] dbus_rdata_i = '0;

  mem_stage_lsu #(.TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .aluc_i(aluc_i), .rD2_i(rD2_i),
    .ram_we_i(ram_we_i), .ram_re_i(ram_re_i), .mem_op_i(mem_op_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wstrb_o(dbus_wstrb_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] err; logic [31:0] rdata; int cyc; } exp_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] strb; logic [31:0] wdata; } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int req_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dbus_req_o) req_cyc <= req_cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  function automatic logic [1:0] ref_err(input bit we, input bit re, input logic [2:0] f3,
                                         input logic [31:0] a);
    int sz;
    if (we && re) return 2'b11;
    if (re) begin
      case (f3)
        3'd0, 3'd4: sz = 1;
        3'd1, 3'd5: sz = 2;
        3'd2:       sz = 4;
        default:    sz = 0;
      endcase
    end else begin
      case (f3)
        3'd0:    sz = 1;
        3'd1:    sz = 2;
        3'd2:    sz = 4;
        default: sz = 0;
      endcase
    end
    if (sz == 0) return 2'b11;
    if ((int'(a[1:0]) % sz) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * int'(a[1:0]));
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256; end
      3'd4: v = v & 32'hFF;
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'd5: v = v & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
    int lane;
    lane = int'(a[1:0]);
    if (f3 == 3'd0) return 4'(1 << lane);
    if (f3 == 3'd1) return 4'(3 << lane);
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h01010101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    bus_t b;
    if (rst_n && done_o) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("err", {30'b0, err_o}, {30'b0, e.err});
        chk("rdata", rdata_o, e.rdata);
        chk("done_cycle", cyc, e.cyc);
      end
    end
    if (rst_n && dbus_req_o && dbus_gnt_i) begin
      if (bus_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
      else begin
        b = bus_q.pop_front();
        chk("bus_addr", dbus_addr_o, b.addr);
        chk("bus_we", {31'b0, dbus_we_o}, {31'b0, b.we});
        if (b.we) begin
          chk("bus_wstrb", {28'b0, dbus_wstrb_o}, {28'b0, b.strb});
          chk("bus_wdata", dbus_wdata_o, b.wdata);
        end
      end
    end
  end

  task automatic do_op(input bit we, input bit re, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int gdly, input int rdly, input logic [31:0] rword,
                       output int reqs);
    exp_t e;
    bus_t b;
    bit   st, ok, seen;
    int   inreq, r0;
    @(posedge clk); #1;
    r0 = req_cyc;
    valid_i = 1'b1; ram_we_i = we; ram_re_i = re; mem_op_i = f3;
    aluc_i = addr; rD2_i = wd; dbus_rdata_i = $urandom();
    st = we || re;
    e.err = ref_err(we, re, f3, addr);
    e.rdata = 32'h0;
    ok = st && (e.err == 2'b00);
    if (st) begin
      if (ok) begin
        inreq = (gdly >= NEVER) ? NEVER : gdly + 1 + (re ? rdly : 0);
        if (inreq > TO) begin
          e.err = 2'b10;
          e.cyc = cyc + TO + 1;
        end else begin
          e.cyc = cyc + 1 + inreq;
          if (re) e.rdata = ref_load(f3, addr, rword);
        end
        if (gdly < TO) begin
          b.addr = addr & 32'hFFFF_FFFC; b.we = we;
          b.strb = ref_strb(f3, addr); b.wdata = ref_wdata(f3, wd);
          bus_q.push_back(b);
        end
      end else begin
        e.cyc = cyc + 1;
      end
      exp_q.push_back(e);
    end
    #1 chk("stall_start", {31'b0, stall_o}, {31'b0, st});
    @(posedge clk); #1;
    valid_i = 1'b0; ram_we_i = 1'b0; ram_re_i = 1'b0;
    aluc_i = $urandom(); rD2_i = $urandom();
    if (ok && gdly < NEVER) begin
      repeat (gdly) begin @(posedge clk); #1; end
      dbus_gnt_i = 1'b1;
      if (re && rdly == 0) begin dbus_rvalid_i = 1'b1; dbus_rdata_i = rword; end
      @(posedge clk); #1;
      dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = $urandom();
      if (re && rdly > 0) begin
        repeat (rdly - 1) begin @(posedge clk); #1; end
        dbus_rvalid_i = 1'b1; dbus_rdata_i = rword;
        @(posedge clk); #1;
        dbus_rvalid_i = 1'b0; dbus_rdata_i = $urandom();
      end
    end
    if (st) begin
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done_o) begin seen = 1'b1; break; end
        chk("stall_busy", {31'b0, stall_o}, 32'd1);
      end
      chk("done_seen", {31'b0, seen}, 32'd1);
      chk("stall_done", {31'b0, stall_o}, 32'd0);
      #1;
    end
    reqs = req_cyc - r0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   {31'b0, dbus_req_o}, 32'd0);
    chk({tag, "_stall"}, {31'b0, stall_o},    32'd0);
    chk({tag, "_done"},  {31'b0, done_o},     32'd0);
    chk({tag, "_rdata"}, rdata_o,             32'd0);
    chk({tag, "_err"},   {30'b0, err_o},      32'd0);
    chk({tag, "_addr"},  dbus_addr_o,         32'd0);
    chk({tag, "_we"},    {31'b0, dbus_we_o},  32'd0);
    chk({tag, "_wstrb"}, {28'b0, dbus_wstrb_o}, 32'd0);
    chk({tag, "_wdata"}, dbus_wdata_o,        32'd0);
  endtask

  initial begin
    int reqs, k, gd, rd, n;
    logic [31:0] a, d, w;
    logic [2:0]  f;

    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    do_op(1, 0, 3'd2, 32'h1000, 32'hDEADBEEF, 0, 0, 32'h0, reqs);
    do_op(1, 0, 3'd0, 32'h1003, 32'h000000A5, 0, 0, 32'h0, reqs);
    do_op(0, 1, 3'd0, 32'h2002, 32'h0, 0, 1, 32'h12F45678, reqs);
    do_op(0, 1, 3'd4, 32'h2002, 32'h0, 0, 1, 32'h12F45678, reqs);

    // Reset in the middle of a load response phase.
    @(posedge clk); #1;
    valid_i = 1'b1; ram_re_i = 1'b1; mem_op_i = 3'd2; aluc_i = 32'h3000;
    bus_q.push_back('{addr: 32'h3000, we: 1'b0, strb: 4'hF, wdata: 32'h0});
    @(posedge clk); #1;
    valid_i = 1'b0; ram_re_i = 1'b0; dbus_gnt_i = 1'b1;
    @(posedge clk); #1;
    dbus_gnt_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hCAFEF00D;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_o) n++;
      if (i == 0) chk("late_rvalid_stall", {31'b0, stall_o}, 32'd0);
      @(posedge clk); #1 dbus_rvalid_i = 1'b0;
    end
    chk("late_rvalid_done", n, 32'd0);

    do_op(0, 1, 3'd1, 32'h2001, 32'h0, 0, 0, 32'h0, reqs);
    chk("misalign_no_req", reqs, 32'd0);
    do_op(1, 1, 3'd2, 32'h2000, 32'h0, 0, 0, 32'h0, reqs);
    chk("illegal_no_req", reqs, 32'd0);
    do_op(0, 0, 3'd2, 32'h2000, 32'h0, 0, 0, 32'h0, reqs);
    do_op(0, 1, 3'd2, 32'h4000, 32'h0, NEVER, 0, 32'h0, reqs);
    chk("timeout_req_cycles", reqs, TO);

    for (int t = 0; t < 80; t++) begin
      k = $urandom_range(0, 9);
      a = $urandom();
      n = $urandom_range(0, 3);
      if (n == 0) a = a & 32'hFFFF_FFFC;
      else if (n == 1) a = a & 32'hFFFF_FFFE;
      d = $urandom(); w = $urandom();
      gd = $urandom_range(0, 2); rd = $urandom_range(0, 3);
      if (k <= 3) begin
        f = 3'($urandom_range(0, 7));
        do_op(0, 1, f, a, d, gd, rd, w, reqs);
      end else if (k <= 7) begin
        f = 3'($urandom_range(0, 4));
        do_op(1, 0, f, a, d, gd, rd, w, reqs);
      end else if (k == 8) begin
        f = 3'($urandom_range(0, 7));
        do_op(1, 1, f, a, d, gd, rd, w, reqs);
      end else begin
        f = 3'($urandom_range(0, 7));
        do_op(0, 0, f, a, d, gd, rd, w, reqs);
      end
    end

    repeat (3) @(posedge clk);
    chk("exp_queue_drained", exp_q.size(), 32'd0);
    chk("bus_queue_drained", bus_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
